controller_sequencer: RTL
=========================

Name: controller_sequencer

Overview:
- Control unit for the 8-bit CPU.
- Drives the program counter's control inputs (cp, ep, lp), plus the load/enable strobes for MAR, RAM, IR, accumulator, B register, ALU and output register.
- Sequence: a one-hot T-state ring counter runs the fixed fetch (T1–T3), then opcode-dependent execute states (T4 onward).
- Sits between the instruction register's opcode nibble and every datapath block on the shared 8-bit bus.

Parameters:
- T_COUNT, 6, number of T-states per instruction. Must be ≥6; states beyond T6 assert no controls.

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  synchronous active-high reset
- opcode  input  4  IR upper nibble, stable from end of T3
- carry  input  1  ALU carry flag, registered externally
- t_state  output  T_COUNT  one-hot current T-state, bit0 = T1
- cp  output  1  PC count enable
- ep  output  1  PC drive-bus enable
- lp  output  1  PC load from bus
- lm  output  1  MAR load
- ce  output  1  RAM drive bus
- li  output  1  IR load
- ei  output  1  IR low nibble drive bus
- la  output  1  accumulator load
- ea  output  1  accumulator drive bus
- su  output  1  ALU subtract select
- eu  output  1  ALU drive bus
- lb  output  1  B register load
- lo  output  1  output register load
- hlt  output  1  halted indicator

Behaviour:
- Reset:
  - clr high at a rising edge sets t_state to T1 (1).
  - While clr is high, every control output and hlt is forced to 0 combinationally.
  - clr wins over every other condition, including halt.
- Ring counter:
  - Advances one state per clk edge: T1→T2→…→T_COUNT→T1.
  - Exactly one bit of t_state is set at all times after reset.
- Control outputs:
  - Combinational from t_state, opcode and carry.
  - Datapath samples them on the edge that ends the state.
  - Any output not listed for a state is 0.
- Fetch (all opcodes):
  - T1: ep, lm
  - T2: cp
  - T3: ce, li
- Execute, by opcode:
  - 0000 LDA: T4 ei, lm; T5 ce, la.
  - 0001 ADD: T4 ei, lm; T5 ce, lb; T6 eu, la.
  - 0010 SUB: T4 ei, lm; T5 ce, lb; T6 eu, su, la.
  - 0011 JMP: T4 ei, lp.
  - 0100 JC: T4 ei, lp only if carry=1; otherwise no controls.
  - 1110 OUT: T4 ea, lo.
  - 1111 HLT: T4 hlt=1.
    - Ring counter holds at T4 indefinitely.
    - All other controls stay 0.
    - Only clr exits the halt.
  - All other opcodes: NOP; execute states assert nothing.
- Invariants:
  - cp and lp are never asserted together.
  - At most one bus driver (ep, ce, ei, ea, eu) is high in any state.
  - opcode changes during T1–T3 have no effect on fetch outputs.

Optional Feature:
- Macro: VARIABLE_CYCLE_EN.
- Defined:
  - After the last state with an active control, the next edge returns to T1.
  - Instruction lengths: LDA 5, ADD/SUB 6, JMP/JC/OUT 4, NOP 3 T-states.
  - JC not taken also takes 4 T-states.
  - HLT behaviour unchanged.
- Undefined: every instruction takes exactly T_COUNT states.

Test Plan:
- Reset:
  - Stimulus: clr=1 for 2 cycles, then 0.
  - Response: t_state=000001 and all controls 0 while clr=1; t_state=000010 one edge after release.
- Fetch plus LDA:
  - Stimulus: opcode=0000, carry=0.
  - Response: T1 ep=lm=1; T2 cp=1; T3 ce=li=1; T4 ei=lm=1; T5 ce=la=1; T6 nothing; then back to T1.
- SUB:
  - Stimulus: opcode=0010.
  - Response: T6 has eu=su=la=1; no other bus driver high.
- JC taken vs not taken:
  - Stimulus: opcode=0100.
  - Response: carry=1 gives T4 ei=lp=1 and cp=0; carry=0 gives all controls 0 in T4.
- HLT then reset:
  - Stimulus: opcode=1111.
  - Response:
    - t_state stays 001000 with hlt=1 for 10+ cycles.
    - clr pulse returns t_state to T1 with hlt=0.
    - clr asserted mid-instruction (at T5 of ADD) also returns to T1 with no la pulse.
- VARIABLE_CYCLE_EN:
  - Stimulus: program sequence JMP, OUT, NOP.
  - Response: T-state counts 4, 4, 3 with the macro defined; 6, 6, 6 without.

Source files
------------

// File: rtl/controller_sequencer_if.sv
// rtl/controller_sequencer_if.sv - opcode/flag inputs and control strobes between sequencer and datapath
// master modport belongs to the sequencer; slave modport to the datapath side.
interface controller_sequencer_if #(
   parameter int T_COUNT = 6
);
   logic [3:0]         opcode;
   logic               carry;
   logic [T_COUNT-1:0] t_state;
   logic               cp;
   logic               ep;
   logic               lp;
   logic               lm;
   logic               ce;
   logic               li;
   logic               ei;
   logic               la;
   logic               ea;
   logic               su;
   logic               eu;
   logic               lb;
   logic               lo;
   logic               hlt;

   modport master (
      input  opcode, carry,
      output t_state, cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt
   );

   modport slave (
      output opcode, carry,
      input  t_state, cp, ep, lp, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt
   );
endinterface

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - one-hot T-state sequencer driving the 8-bit CPU datapath strobes
// Optional VARIABLE_CYCLE_EN: return to T1 right after an instruction's last active state.
module controller_sequencer #(
   parameter int T_COUNT = 6
) (
   input  logic                    clk,
   input  logic                    clr,
   controller_sequencer_if.master  bus
);
   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_JMP = 4'b0011;
   localparam logic [3:0] OP_JC  = 4'b0100;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [T_COUNT-1:0] T1_ONEHOT = {{(T_COUNT-1){1'b0}}, 1'b1};

   logic [T_COUNT-1:0] t_state_q;
   logic [T_COUNT-1:0] t_state_d;
   logic               halted;
   logic               last_state;

   logic t1, t2, t3, t4, t5, t6;
   assign t1 = t_state_q[0];
   assign t2 = t_state_q[1];
   assign t3 = t_state_q[2];
   assign t4 = t_state_q[3];
   assign t5 = t_state_q[4];
   assign t6 = t_state_q[5];

   always_ff @(posedge clk) begin
      if (clr) begin
         t_state_q <= T1_ONEHOT;
      end else begin
         t_state_q <= t_state_d;
      end
   end

   always_comb begin
      halted = t4 && (bus.opcode == OP_HLT);
`ifdef VARIABLE_CYCLE_EN
      case (bus.opcode)
         OP_LDA:                 last_state = t5;
         OP_ADD, OP_SUB:         last_state = t6;
         OP_JMP, OP_JC, OP_OUT:  last_state = t4;
         OP_HLT:                 last_state = 1'b0;
         default:                last_state = t3;
      endcase
`else
      last_state = t_state_q[T_COUNT-1];
`endif
      if (halted) begin
         t_state_d = t_state_q;
      end else if (last_state) begin
         t_state_d = T1_ONEHOT;
      end else begin
         t_state_d = {t_state_q[T_COUNT-2:0], t_state_q[T_COUNT-1]};
      end
   end

   always_comb begin
      bus.cp  = 1'b0;
      bus.ep  = 1'b0;
      bus.lp  = 1'b0;
      bus.lm  = 1'b0;
      bus.ce  = 1'b0;
      bus.li  = 1'b0;
      bus.ei  = 1'b0;
      bus.la  = 1'b0;
      bus.ea  = 1'b0;
      bus.su  = 1'b0;
      bus.eu  = 1'b0;
      bus.lb  = 1'b0;
      bus.lo  = 1'b0;
      bus.hlt = 1'b0;
      if (!clr) begin
         // Fetch states ignore the opcode so a changing IR cannot disturb them.
         if (t1) begin
            bus.ep = 1'b1;
            bus.lm = 1'b1;
         end
         if (t2) begin
            bus.cp = 1'b1;
         end
         if (t3) begin
            bus.ce = 1'b1;
            bus.li = 1'b1;
         end
         if (t4) begin
            case (bus.opcode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  bus.ei = 1'b1;
                  bus.lm = 1'b1;
               end
               OP_JMP: begin
                  bus.ei = 1'b1;
                  bus.lp = 1'b1;
               end
               OP_JC: begin
                  bus.ei = bus.carry;
                  bus.lp = bus.carry;
               end
               OP_OUT: begin
                  bus.ea = 1'b1;
                  bus.lo = 1'b1;
               end
               OP_HLT:  bus.hlt = 1'b1;
               default: ;
            endcase
         end
         if (t5) begin
            case (bus.opcode)
               OP_LDA: begin
                  bus.ce = 1'b1;
                  bus.la = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  bus.ce = 1'b1;
                  bus.lb = 1'b1;
               end
               default: ;
            endcase
         end
         if (t6) begin
            case (bus.opcode)
               OP_ADD: begin
                  bus.eu = 1'b1;
                  bus.la = 1'b1;
               end
               OP_SUB: begin
                  bus.eu = 1'b1;
                  bus.su = 1'b1;
                  bus.la = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.t_state = t_state_q;
endmodule
